mem_sweep_ctrl: RTL and testbench
=================================

MEM_SWEEP_CTRL -- requirements
Module: mem_sweep_ctrl

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 6, giving the word-address width (64-word RAM).
REQ-002 The module SHALL have parameter HOLD_CYCLES, default 50_000_000, giving the number of cycles per read display step in auto mode; legal range 1 to 2^32-1.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port start, input, 1: level; sampled only in IDLE.
REQ-006 Port step, input, 1: debounced button level; each rising edge advances the read display.
REQ-007 Port auto_step, input, 1: 1 selects timed advance every HOLD_CYCLES; step is then ignored.
REQ-008 Port base_addr, input, ADDR_W: first word address; latched at start.
REQ-009 Port len, input, ADDR_W: word count; 0 means 2^ADDR_W words; latched at start.
REQ-010 Port pattern_sel, input, 2: write pattern code (00=0000_000F, 01=0000_0DB0, 10=003C_C381, 11=FFFF_FFFF); latched at start.
REQ-011 Port rotate, input, 1: 1 means the pattern code advances by 1 (mod 4) per word written; latched at start.
REQ-012 Port Mem_Addr, output, ADDR_W: RAM word address.
REQ-013 Port MUX, output, 2: write pattern code in WRITE; byte lane (0=[7:0] .. 3=[31:24]) in READ.
REQ-014 Ports Mem_Write and Mem_Read, outputs, 1 each: RAM strobes, never both 1.
REQ-015 Ports busy and done, outputs, 1 each: busy is 1 in WRITE/READ/DONE; done is a one-cycle pulse.

Function
REQ-016 The FSM SHALL have states IDLE, WRITE, READ, and DONE; all outputs SHALL be registered.
REQ-017 In IDLE with start=1 at edge T, the FSM SHALL latch the inputs and enter WRITE, with Mem_Addr=base_addr, Mem_Write=1, and MUX=pattern_sel visible after T.
REQ-018 In WRITE, the FSM SHALL write one word per cycle for exactly N words (N=len, or 64 if len=0).
REQ-019 In WRITE, the address SHALL increment mod 2^ADDR_W (63 wraps to 0).
REQ-020 In WRITE, MUX SHALL be pattern_sel+k mod 4 for word k if rotate=1, and pattern_sel otherwise.
REQ-021 After the Nth write, the next cycle SHALL be READ, with Mem_Write=0, Mem_Read=1, Mem_Addr=base_addr, and MUX=0.
REQ-022 In READ, Mem_Addr and MUX SHALL hold until an advance event.
REQ-023 An advance SHALL increment MUX; when MUX=3 it SHALL wrap MUX to 0 and increment Mem_Addr mod 2^ADDR_W.
REQ-024 In manual mode, an advance event SHALL be step=1 with the registered previous step=0; the update SHALL occur at the same edge; holding step high SHALL advance only once.
REQ-025 In auto mode, a 32-bit hold counter SHALL clear on READ entry and on each advance; an advance SHALL occur when the counter reaches HOLD_CYCLES-1.
REQ-026 A change of auto_step mid-READ SHALL clear the hold counter and re-seed the step edge register with the current step value, so that no spurious advance occurs.
REQ-027 An advance at the last byte (word N-1, MUX=3) SHALL enter DONE, with Mem_Read=0 and done=1 for one cycle; the FSM SHALL then return to IDLE with busy=0.
REQ-028 start, step, and input changes SHALL be ignored outside their states; start held high in DONE SHALL NOT restart until IDLE is reached.
REQ-029 In IDLE, Mem_Addr, MUX, Mem_Write, and Mem_Read SHALL be 0.

Reset
REQ-030 rst=1 at any edge SHALL force IDLE, set Mem_Addr=0, MUX=0, Mem_Write=0, Mem_Read=0, busy=0, and done=0, clear the hold counter, and set the step edge register to 0.
REQ-031 rst SHALL take priority over start and step; reset mid-WRITE SHALL drop Mem_Write to 0 at the same edge, and no further writes SHALL occur.

Verification
REQ-032 base=5, len=3, pattern=01, rotate=0, start pulse -> Mem_Write high for exactly 3 cycles at addresses 5,6,7 with MUX=1; then READ at address 5 with MUX=0.
REQ-033 base=62, len=4, rotate=1, pattern=11 -> write addresses 62,63,0,1 with MUX 3,0,1,2.
REQ-034 Manual READ with len=2 -> 8 step pulses walk (base,0..3),(base+1,0..3); the 8th pulse gives done for 1 cycle then IDLE; step held high for 10 cycles counts as 1 advance.
REQ-035 auto_step=1, HOLD_CYCLES=4, len=1 -> MUX changes every 4 cycles; done occurs 16 cycles after READ entry.
REQ-036 len=0, base=0 -> 64 write cycles, last address 63, read starts at address 0.
REQ-037 rst asserted in the 2nd WRITE cycle -> the next cycle shows all outputs 0 and IDLE; a subsequent start runs normally; start in DONE is ignored.

Source files
------------

// File: rtl/mem_sweep_ctrl.sv
`timescale 1ns/1ps
// mem_sweep_ctrl: fills a window of RAM with a test pattern, then walks the
// same window back out one byte lane at a time, either on button steps or on
// a fixed hold timer.
//
// state | meaning
// IDLE  | strobes low, waiting for start
// WRITE | one pattern word written per cycle over the latched window
// READ  | one word/byte-lane displayed, advanced by step edge or hold timer
// DONE  | one-cycle done pulse, then back to IDLE
module mem_sweep_ctrl #(
  parameter int          ADDR_W      = 6,
  parameter logic [31:0] HOLD_CYCLES = 32'd50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              step,
  input  logic              auto_step,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic [1:0]        pattern_sel,
  input  logic              rotate,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [1:0]        MUX,
  output logic              Mem_Write,
  output logic              Mem_Read,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [1:0]        mux_n;
  logic              wr_n, rd_n, busy_n, done_n;
  logic [ADDR_W-1:0] base_q, base_n;
  logic [ADDR_W-1:0] len_m1_q, len_m1_n;   // word count minus one; len=0 wraps to full RAM
  logic              rot_q, rot_n;
  logic [ADDR_W-1:0] left_q, left_n;       // words remaining after the current one
  logic [31:0]       hold_q, hold_n;
  logic              step_prev, auto_prev;
  logic              mode_change, advance;

  // Advance decode: a mode switch swallows the advance on that edge so the
  // freshly re-seeded timer / step history cannot fire spuriously.
  always_comb begin
    mode_change = (auto_step != auto_prev);
    if (mode_change)
      advance = 1'b0;
    else if (auto_step)
      advance = (hold_q == (HOLD_CYCLES - 32'd1));
    else
      advance = step & ~step_prev;
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n  = state;
    addr_n   = Mem_Addr;
    mux_n    = MUX;
    wr_n     = 1'b0;
    rd_n     = 1'b0;
    busy_n   = 1'b0;
    done_n   = 1'b0;
    base_n   = base_q;
    len_m1_n = len_m1_q;
    rot_n    = rot_q;
    left_n   = left_q;
    hold_n   = '0;
    unique case (state)
      IDLE: begin
        addr_n = '0;
        mux_n  = '0;
        if (start) begin
          state_n  = WRITE;
          base_n   = base_addr;
          len_m1_n = len - ADDR_W'(1);
          rot_n    = rotate;
          left_n   = len - ADDR_W'(1);
          addr_n   = base_addr;
          mux_n    = pattern_sel;
          wr_n     = 1'b1;
          busy_n   = 1'b1;
        end
      end
      WRITE: begin
        busy_n = 1'b1;
        if (left_q == '0) begin
          state_n = READ;
          rd_n    = 1'b1;
          addr_n  = base_q;
          mux_n   = '0;
          left_n  = len_m1_q;
        end else begin
          wr_n   = 1'b1;
          left_n = left_q - ADDR_W'(1);
          addr_n = Mem_Addr + ADDR_W'(1);
          if (rot_q) mux_n = MUX + 2'd1;
        end
      end
      READ: begin
        busy_n = 1'b1;
        rd_n   = 1'b1;
        if (auto_step && !mode_change && !advance) hold_n = hold_q + 32'd1;
        if (advance) begin
          if (MUX == 2'd3) begin
            if (left_q == '0) begin
              state_n = DONE;
              rd_n    = 1'b0;
              done_n  = 1'b1;
            end else begin
              mux_n  = '0;
              addr_n = Mem_Addr + ADDR_W'(1);
              left_n = left_q - ADDR_W'(1);
            end
          end else begin
            mux_n = MUX + 2'd1;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        addr_n  = '0;
        mux_n   = '0;
      end
      default: begin
        state_n = IDLE;
        addr_n  = '0;
        mux_n   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      Mem_Addr  <= '0;
      MUX       <= '0;
      Mem_Write <= 1'b0;
      Mem_Read  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      base_q    <= '0;
      len_m1_q  <= '0;
      rot_q     <= 1'b0;
      left_q    <= '0;
      hold_q    <= '0;
      step_prev <= 1'b0;
      auto_prev <= 1'b0;
    end else begin
      state     <= state_n;
      Mem_Addr  <= addr_n;
      MUX       <= mux_n;
      Mem_Write <= wr_n;
      Mem_Read  <= rd_n;
      busy      <= busy_n;
      done      <= done_n;
      base_q    <= base_n;
      len_m1_q  <= len_m1_n;
      rot_q     <= rot_n;
      left_q    <= left_n;
      hold_q    <= hold_n;
      step_prev <= step;
      auto_prev <= auto_step;
    end
  end

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
`timescale 1ns/1ps
// Directed bench for mem_sweep_ctrl: expected writes are queued when a run
// is launched and popped by a negedge monitor; reads are checked in line.
module tb_mem_sweep_ctrl;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, step = 1'b0, auto_step = 1'b0, rotate = 1'b0;
  logic [AW-1:0] base_addr = '0, len = '0;
  logic [1:0]    pattern_sel = '0;
  logic [AW-1:0] Mem_Addr;
  logic [1:0]    MUX;
  logic          Mem_Write, Mem_Read, busy, done;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  wq[$];
  logic [7:0]  exp_w;

  mem_sweep_ctrl #(.ADDR_W(AW), .HOLD_CYCLES(32'd4)) dut (
    .clk(clk), .rst(rst), .start(start), .step(step), .auto_step(auto_step),
    .base_addr(base_addr), .len(len), .pattern_sel(pattern_sel), .rotate(rotate),
    .Mem_Addr(Mem_Addr), .MUX(MUX), .Mem_Write(Mem_Write), .Mem_Read(Mem_Read),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every write cycle must match the head of the expected-write queue.
  always @(negedge clk) begin
    check("strobe_excl", 32'(Mem_Write & Mem_Read), 32'd0);
    if (Mem_Write) begin
      check("write_pending", 32'(wq.size() > 0), 32'd1);
      if (wq.size() > 0) begin
        exp_w = wq.pop_front();
        check("wr_addr", 32'(Mem_Addr), 32'(exp_w[7:2]));
        check("wr_mux", 32'(MUX), 32'(exp_w[1:0]));
      end
    end
  end

  task automatic push_writes(input int b, input int l, input int p, input int r);
    int n;
    n = (l == 0) ? 64 : l;
    for (int k = 0; k < n; k++)
      wq.push_back({6'((b + k) % 64), 2'(r != 0 ? (p + k) % 4 : p)});
  endtask

  task automatic start_run(input int b, input int l, input int p, input int r);
    base_addr = AW'(b); len = AW'(l); pattern_sel = 2'(p); rotate = (r != 0);
    push_writes(b, l, p, r);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_read(input string tag, input int a, input int m);
    check({tag, "_rd"},   32'(Mem_Read), 32'd1);
    check({tag, "_wr"},   32'(Mem_Write), 32'd0);
    check({tag, "_addr"}, 32'(Mem_Addr), 32'(a % 64));
    check({tag, "_mux"},  32'(MUX), 32'(m));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_idle_outs"}, {24'd0, Mem_Addr, MUX}, 32'd0);
    check({tag, "_idle_flags"}, {28'd0, Mem_Write, Mem_Read, busy, done}, 32'd0);
  endtask

  // Manual walk through a window; 'first' is the index of the next advance.
  task automatic read_manual(input string tag, input int b, input int n, input int first);
    int total;
    total = 4 * n;
    for (int i = first; i < total; i++) begin
      step = 1'b1;
      tick();
      if (i < total - 1) begin
        check_read(tag, b + (i + 1) / 4, (i + 1) % 4);
      end else begin
        check({tag, "_done"}, {29'd0, done, Mem_Read, busy}, 32'b101);
      end
      step = 1'b0;
      tick();
      if (i == total - 1) check_idle({tag, "_end"});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    tick(); tick();
    check_idle("reset");
    rst = 1'b0;
    tick();
    check_idle("post_reset");

    // Plain pattern, no rotation, short window.
    start_run(5, 3, 1, 0);
    repeat (3) tick();
    check("t1_wq_empty", 32'(wq.size()), 32'd0);
    check_read("t1_entry", 5, 0);
    read_manual("t1", 5, 3, 0);

    // Rotating pattern across the top-of-RAM wrap.
    start_run(62, 4, 3, 1);
    repeat (4) tick();
    check("t2_wq_empty", 32'(wq.size()), 32'd0);
    check_read("t2_entry", 62, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    check_idle("t2_reset");

    // Manual read; a long step press counts once.
    start_run(10, 2, 2, 0);
    repeat (2) tick();
    check_read("t3_entry", 10, 0);
    step = 1'b1;
    repeat (10) tick();
    check_read("t3_held", 10, 1);
    step = 1'b0;
    tick();
    read_manual("t3", 10, 2, 1);

    // Timed advance with a 4-cycle hold; step must be ignored.
    auto_step = 1'b1;
    start_run(20, 1, 2, 1);
    tick();
    check_read("t4_entry", 20, 0);
    for (int c = 1; c <= 16; c++) begin
      step = (c % 2 == 1);
      tick();
      if (c < 16) check_read("t4_step", 20, c / 4);
      else check("t4_done", {29'd0, done, Mem_Read, busy}, 32'b101);
    end
    step = 1'b0;
    tick();
    check_idle("t4_end");
    auto_step = 1'b0;
    tick();

    // len=0 covers the whole RAM.
    start_run(0, 0, 0, 0);
    repeat (64) tick();
    check("t5_wq_empty", 32'(wq.size()), 32'd0);
    check_read("t5_entry", 0, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    check_idle("t5_reset");

    // Reset during the second write cycle stops writing immediately.
    base_addr = 6'd30; len = 6'd5; pattern_sel = 2'd1; rotate = 1'b1;
    push_writes(30, 2, 1, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check_idle("t6_reset");
    rst = 1'b0;
    repeat (3) tick();
    check("t6_wq_empty", 32'(wq.size()), 32'd0);

    // Normal run afterwards, start held high through DONE.
    start_run(40, 1, 0, 0);
    start = 1'b1;
    tick();
    check_read("t6_entry", 40, 0);
    read_manual("t6", 40, 1, 0);
    push_writes(40, 1, 0, 0);
    tick();
    check("t6_restart", {30'd0, Mem_Write, busy}, 32'b11);
    start = 1'b0;
    tick();
    check_read("t6_reentry", 40, 0);
    check("t6_wq_final", 32'(wq.size()), 32'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    check_idle("t6_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
